// File: rtl/semafor_pkg.sv
// Shared types and constants for the semafor traffic-light controller.
// Night blink state exists only when SEMAFOR_NIGHT_MODE_EN is defined.
package semafor_pkg;

    typedef enum logic [2:0] {
        AR_A   = 3'd0,
        MAIN_G = 3'd1,
        MAIN_Y = 3'd2,
        AR_B   = 3'd3,
        SIDE_G = 3'd4,
        SIDE_Y = 3'd5
`ifdef SEMAFOR_NIGHT_MODE_EN
        ,
        BLINK  = 3'd6
`endif
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    localparam int CNT_W_DEF = 8;
    localparam int T_MG_DEF  = 10;
    localparam int T_Y_DEF   = 3;
    localparam int T_AR_DEF  = 1;
    localparam int T_SG_DEF  = 6;

    // Counter reload value: duration minus one, never below zero.
    function automatic int dur_m1(input int d);
        return (d < 1) ? 0 : d - 1;
    endfunction

endpackage

// File: rtl/semafor_ctrl_phase_timer.sv
// Loadable down-counter measuring phase length in timebase ticks.
// done is high while the count sits at zero.
module phase_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/semafor_ctrl.sv
// Two-road traffic-light controller with pedestrian crossing (Moore FSM).
// Optional night blink mode: define SEMAFOR_NIGHT_MODE_EN.
module semafor_ctrl
    import semafor_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int T_MG  = T_MG_DEF,
    parameter int T_Y   = T_Y_DEF,
    parameter int T_AR  = T_AR_DEF,
    parameter int T_SG  = T_SG_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       car_side,
    input  logic       ped_req,
`ifdef SEMAFOR_NIGHT_MODE_EN
    input  logic       night,
`endif
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy,
    output logic       ped_walk,
    output logic       ped_ack,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] LD_MG = CNT_W'(dur_m1(T_MG));
    localparam logic [CNT_W-1:0] LD_Y  = CNT_W'(dur_m1(T_Y));
    localparam logic [CNT_W-1:0] LD_AR = CNT_W'(dur_m1(T_AR));
    localparam logic [CNT_W-1:0] LD_SG = CNT_W'(dur_m1(T_SG));

    state_t           state;
    state_t           next;
    logic             ped_pend;
    logic             ack_q;
    logic             done;
    logic             timeout;
    logic             load;
    logic             enter_sg;
    logic             accept;
    logic [CNT_W-1:0] load_val;
`ifdef SEMAFOR_NIGHT_MODE_EN
    logic             blink;
`endif

    assign timeout = tick && done;

    always_comb begin
        next = state;
        case (state)
            AR_A: begin
`ifdef SEMAFOR_NIGHT_MODE_EN
                if (timeout) next = night ? BLINK : MAIN_G;
`else
                if (timeout) next = MAIN_G;
`endif
            end
            MAIN_G: begin
`ifdef SEMAFOR_NIGHT_MODE_EN
                if (tick && night) next = MAIN_Y;
                else
`endif
                if (timeout && (car_side || ped_pend)) next = MAIN_Y;
            end
            MAIN_Y: if (timeout) next = AR_B;
            AR_B:   if (timeout) next = SIDE_G;
            SIDE_G: if (timeout) next = SIDE_Y;
            SIDE_Y: if (timeout) next = AR_A;
`ifdef SEMAFOR_NIGHT_MODE_EN
            BLINK:  if (tick && !night) next = AR_A;
`endif
            default: next = AR_A;
        endcase
    end

    // Any state change, including recovery from an illegal code, reloads.
    assign load = (next != state);

    always_comb begin
        load_val = '0;
        case (next)
            AR_A:    load_val = LD_AR;
            MAIN_G:  load_val = LD_MG;
            MAIN_Y:  load_val = LD_Y;
            AR_B:    load_val = LD_AR;
            SIDE_G:  load_val = LD_SG;
            SIDE_Y:  load_val = LD_Y;
            default: load_val = '0;
        endcase
    end

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_AR)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    assign enter_sg = (next == SIDE_G) && (state != SIDE_G);

    always_comb begin
        accept = ped_req && !ped_pend && (state != SIDE_G) && !enter_sg;
`ifdef SEMAFOR_NIGHT_MODE_EN
        if (state == BLINK) accept = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= AR_A;
            ped_pend <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state <= next;
            ack_q <= accept;
            if (enter_sg) begin
                ped_pend <= 1'b0;
            end else if (accept) begin
                ped_pend <= 1'b1;
            end
        end
    end

`ifdef SEMAFOR_NIGHT_MODE_EN
    // Yellow phase of the blink: on at entry, flips on every tick.
    always_ff @(posedge clk) begin
        if (rst || state != BLINK) begin
            blink <= 1'b1;
        end else if (tick) begin
            blink <= ~blink;
        end
    end
`endif

    always_comb begin
        main_rgy = OFF;
        side_rgy = OFF;
        ped_walk = 1'b0;
        case (state)
            MAIN_G: begin
                main_rgy = GRN;
                side_rgy = RED;
            end
            MAIN_Y: begin
                main_rgy = YEL;
                side_rgy = RED;
            end
            SIDE_G: begin
                main_rgy = RED;
                side_rgy = GRN;
                ped_walk = 1'b1;
            end
            SIDE_Y: begin
                main_rgy = RED;
                side_rgy = YEL;
            end
`ifdef SEMAFOR_NIGHT_MODE_EN
            BLINK: begin
                main_rgy = blink ? YEL : OFF;
                side_rgy = blink ? YEL : OFF;
            end
`endif
            default: begin
                main_rgy = RED;
                side_rgy = RED;
            end
        endcase
    end

    assign ped_ack = ack_q;
    assign state_o = state;

endmodule
